// File: rtl/ble_phy_pkg.sv
// Shared definitions for the BLE PHY receive blocks.
//   state_t     : decoder FSM state encoding
//   REP_*/DEPTH_* : legal parameter limits for the repetition decoder
//   clog2()     : constant ceil(log2(v)), usable in parameter lists
package ble_phy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT_EN = 2'd2,
    READ    = 2'd3
  } state_t;

  localparam int REP_MIN   = 3;
  localparam int REP_MAX   = 7;
  localparam int DEPTH_MIN = 8;
  localparam int DEPTH_MAX = 1024;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rep_bit_ram_ble.sv
// 1-bit wide, DEPTH-deep simple dual-port RAM.
//   clk, reset            : clock, async active-low reset (read register only)
//   we, waddr, wdata      : synchronous write port
//   re, raddr, rdata      : registered read port; rdata updates only when re=1
// The array itself has no reset.
module rep_bit_ram_ble #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= 1'b0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rep_majority_decoder_ble.sv
// Repetition-code majority decoder for the BLE receive path.
// Coded bits arrive in groups of REP; each group is voted to one bit and stored.
// When the burst ends the stored bits are replayed under consumer flow control.
//   clk, reset       : clock, async active-low reset
//   valid_in/data_in : coded bit stream; a burst is a contiguous valid_in run
//   enable           : consumer ready (read issue only while high)
//   valid_out/data_out : decoded bit stream, one cycle after each read issue
//   finished         : 1 when ready for a new burst
//   bit_count, disagree_count, overflow : statistics of the last burst
// REP must be odd in 3..7, DEPTH a power of two in 8..1024.
module rep_majority_decoder_ble
  import ble_phy_pkg::*;
#(
  parameter  int REP   = 3,
  parameter  int DEPTH = 64,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        data_in,
  input  logic        enable,
  output logic        valid_out,
  output logic        data_out,
  output logic        finished,
  output logic [AW:0] bit_count,
  output logic [AW:0] disagree_count,
  output logic        overflow
);

  localparam int GW = clog2(REP);
  localparam int OW = clog2(REP + 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(REP - 1);
  localparam logic [OW-1:0] HALF     = OW'(REP / 2);
  localparam logic [OW-1:0] ALL_ONES = OW'(REP);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  state_t        state;
  logic [GW-1:0] grp_cnt;
  logic [OW-1:0] ones;
  logic [AW-1:0] rd_ptr;
  logic          draining;   // last bit issued, waiting for it to be presented

  logic [OW-1:0] tally;      // ones including the bit arriving this cycle
  logic          group_done, vote, mixed, we, re;

  assign tally      = ones + OW'(data_in);
  assign group_done = (state == COLLECT) && valid_in && (grp_cnt == GRP_LAST);
  assign vote       = tally > HALF;
  assign mixed      = (tally != '0) && (tally != ALL_ONES);
  assign we         = group_done && (bit_count < FULL);
  assign re         = (state == READ) && enable && !draining;

  rep_bit_ram_ble #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (bit_count[AW-1:0]),
    .wdata (vote),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      grp_cnt        <= '0;
      ones           <= '0;
      rd_ptr         <= '0;
      draining       <= 1'b0;
      valid_out      <= 1'b0;
      finished       <= 1'b1;
      bit_count      <= '0;
      disagree_count <= '0;
      overflow       <= 1'b0;
    end else begin
      // RAM read data lands one cycle after issue, so valid tracks re.
      valid_out <= re;
      case (state)
        IDLE: begin
          if (valid_in) begin
            state          <= COLLECT;
            bit_count      <= '0;
            disagree_count <= '0;
            overflow       <= 1'b0;
            grp_cnt        <= GW'(1);
            ones           <= OW'(data_in);
          end
        end
        COLLECT: begin
          if (!valid_in) begin
            // partial group is simply discarded
            grp_cnt <= '0;
            ones    <= '0;
            if (bit_count == '0) begin
              state <= IDLE;
            end else begin
              state    <= WAIT_EN;
              finished <= 1'b0;
            end
          end else if (grp_cnt == GRP_LAST) begin
            grp_cnt <= '0;
            ones    <= '0;
            if (bit_count < FULL) bit_count <= bit_count + 1'b1;
            else                  overflow  <= 1'b1;
            if (mixed && (disagree_count != '1))
              disagree_count <= disagree_count + 1'b1;
          end else begin
            grp_cnt <= grp_cnt + 1'b1;
            ones    <= tally;
          end
        end
        WAIT_EN: begin
          if (enable) begin
            state    <= READ;
            rd_ptr   <= '0;
            draining <= 1'b0;
          end
        end
        READ: begin
          // Leave only once the last bit is on the output, so finished
          // rises on the same edge valid_out falls.
          if (draining) begin
            state    <= IDLE;
            finished <= 1'b1;
            draining <= 1'b0;
          end else if (enable) begin
            rd_ptr <= rd_ptr + 1'b1;
            if ({1'b0, rd_ptr} == bit_count - 1'b1) draining <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rep_majority_decoder_ble.sv
// Scoreboard bench: two decoders (d0: REP=3 DEPTH=8, d1: REP=5 DEPTH=64).
// Stimulus pushes hand-computed decoded bits into a per-DUT queue; a monitor
// per DUT pops and compares on every valid_out.
module tb_rep_majority_decoder_ble;

  logic       clk;
  logic [1:0] rst, valid_in, data_in, enable;
  logic [1:0] valid_out, data_out, finished, ovf;
  logic [3:0] bc0, dc0;
  logic [6:0] bc1, dc1;

  int checks   = 0;
  int failures = 0;
  bit exp_q0[$];
  bit exp_q1[$];

  rep_majority_decoder_ble #(.REP(3), .DEPTH(8)) d0 (
    .clk(clk), .reset(rst[0]), .valid_in(valid_in[0]), .data_in(data_in[0]),
    .enable(enable[0]), .valid_out(valid_out[0]), .data_out(data_out[0]),
    .finished(finished[0]), .bit_count(bc0), .disagree_count(dc0), .overflow(ovf[0])
  );

  rep_majority_decoder_ble #(.REP(5), .DEPTH(64)) d1 (
    .clk(clk), .reset(rst[1]), .valid_in(valid_in[1]), .data_in(data_in[1]),
    .enable(enable[1]), .valid_out(valid_out[1]), .data_out(data_out[1]),
    .finished(finished[1]), .bit_count(bc1), .disagree_count(dc1), .overflow(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bc_of(input int d);
    return (d == 0) ? 32'(bc0) : 32'(bc1);
  endfunction
  function automatic logic [31:0] dc_of(input int d);
    return (d == 0) ? 32'(dc0) : 32'(dc1);
  endfunction
  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // monitors
  always @(negedge clk) begin
    if (valid_out[0] === 1'b1) begin
      if (exp_q0.size() == 0) chk("d0_unexpected_valid_out", 1, 0);
      else chk("d0_data_out", data_out[0], exp_q0.pop_front());
    end
  end
  always @(negedge clk) begin
    if (valid_out[1] === 1'b1) begin
      if (exp_q1.size() == 0) chk("d1_unexpected_valid_out", 1, 0);
      else chk("d1_data_out", data_out[1], exp_q1.pop_front());
    end
  end

  task automatic push_exp(input int d, input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      if (bits[i] == "1" || bits[i] == "0") begin
        if (d == 0) exp_q0.push_back(bits[i] == "1");
        else        exp_q1.push_back(bits[i] == "1");
      end
    end
  endtask

  // drives one contiguous burst, starting and ending at posedge+1
  task automatic send(input int d, input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      if (bits[i] == "1" || bits[i] == "0") begin
        valid_in[d] = 1'b1;
        data_in[d]  = (bits[i] == "1");
        @(posedge clk); #1;
      end
    end
    valid_in[d] = 1'b0;
    data_in[d]  = 1'b0;
  endtask

  task automatic finish_burst(input int d, input bit chk_low, input int ebc,
                              input int edc, input int eov);
    logic prev_vo;
    bit   seen;
    if (chk_low) begin
      repeat (3) @(negedge clk);
      chk($sformatf("d%0d_finished_low", d), finished[d], 0);
    end
    prev_vo = valid_out[d];
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (finished[d] === 1'b1) begin
        seen = 1;
        chk($sformatf("d%0d_finish_on_valid_fall", d), {prev_vo, valid_out[d]}, 2'b10);
      end
      prev_vo = valid_out[d];
    end
    chk($sformatf("d%0d_finished_rise_in_time", d), seen, 1);
    repeat (2) @(negedge clk);
    chk($sformatf("d%0d_all_bits_out", d), qsize(d), 0);
    chk($sformatf("d%0d_bit_count", d), bc_of(d), ebc);
    chk($sformatf("d%0d_disagree_count", d), dc_of(d), edc);
    chk($sformatf("d%0d_overflow", d), ovf[d], eov);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input int d);
    chk($sformatf("d%0d_rst_valid_out", d), valid_out[d], 0);
    chk($sformatf("d%0d_rst_data_out", d), data_out[d], 0);
    chk($sformatf("d%0d_rst_finished", d), finished[d], 1);
    chk($sformatf("d%0d_rst_bit_count", d), bc_of(d), 0);
    chk($sformatf("d%0d_rst_disagree", d), dc_of(d), 0);
    chk($sformatf("d%0d_rst_overflow", d), ovf[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit all_high, stall_ok;
    int en_seq[9] = '{1, 1, 0, 0, 1, 0, 0, 1, 0};

    rst = 2'b00; valid_in = 2'b00; data_in = 2'b00; enable = 2'b11;
    #12;
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(negedge clk); rst = 2'b11;
    @(posedge clk); #1;

    // REP=3 basic: 111 000 101 010
    push_exp(0, "1010");
    send(0, "111 000 101 010");
    finish_burst(0, 1, 4, 2, 0);

    // REP=5: 11000 11100
    push_exp(1, "01");
    send(1, "11000 11100");
    finish_burst(1, 1, 2, 2, 0);

    // REP=3 with trailing partial group
    push_exp(0, "10");
    send(0, "111 000 11");
    finish_burst(0, 1, 2, 0, 0);

    // 2-bit burst: no complete group, no readout
    send(0, "11");
    all_high = 1;
    repeat (6) begin
      @(negedge clk);
      if (finished[0] !== 1'b1) all_high = 0;
    end
    chk("d0_short_burst_finished_high", all_high, 1);
    chk("d0_short_burst_bit_count", bc0, 0);
    @(posedge clk); #1;

    // overflow at DEPTH=8: 10 groups, last two dropped
    push_exp(0, "10101001");
    send(0, "111 000 110 001 111 000 100 011 111 000");
    finish_burst(0, 1, 8, 4, 1);

    // backpressure, with valid_in pulses while reading
    enable[0] = 1'b0;
    push_exp(0, "0101");
    send(0, "000 111 000 111");
    repeat (4) @(negedge clk);
    chk("d0_wait_en_finished_low", finished[0], 0);
    chk("d0_wait_en_no_valid", valid_out[0], 0);
    @(posedge clk); #1;
    stall_ok = 1;
    for (int i = 0; i < 9; i++) begin
      enable[0]   = en_seq[i][0];
      valid_in[0] = (i == 2 || i == 5);
      data_in[0]  = (i == 2 || i == 5);
      @(posedge clk); #1;
      if (en_seq[i] == 0 && valid_out[0] !== 1'b0) stall_ok = 0;
    end
    valid_in[0] = 1'b0; data_in[0] = 1'b0;
    chk("d0_stall_valid_low", stall_ok, 1);
    enable[0] = 1'b1;
    finish_burst(0, 0, 4, 0, 0);

    // reset in the middle of readout
    push_exp(1, "1010");
    send(1, "11111 00000 11111 00000");
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        if (valid_out[1] === 1'b1) got = 1;
      end
      chk("d1_readout_started", got, 1);
    end
    @(posedge clk); #1;
    rst[1] = 1'b0;
    exp_q1.delete();
    #2;
    chk_reset_vals(1);
    @(negedge clk); rst[1] = 1'b1;
    @(posedge clk); #1;
    push_exp(1, "01");
    send(1, "00000 11011");
    finish_burst(1, 1, 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
